bit_serial_adder: RTL



---
 rtl/bit_serial_pkg.sv | 12 +
 rtl/serial_fa_cell.sv | 18 +
 rtl/bit_serial_adder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bit_serial_pkg.sv
// Shared types and defaults for the bit-serial adder.
package bit_serial_pkg;

   localparam int unsigned DefaultWidth = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit sum/carry cell in propagate/generate form; purely combinational.
module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;
   logic g;

   assign p  = a ^ b;
   assign g  = a & b;
   assign s  = p ^ ci;
   assign co = g | (p & ci);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder with start/busy/done handshake.
// Define BIT_SERIAL_SUB_EN to add the 'sub' port (a - b via ~b and forced carry-in).
module bit_serial_adder
   import bit_serial_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef BIT_SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] b_load;
   logic             carry_load;
   logic             accept;
   logic             last_step;
   logic             cell_s;
   logic             cell_co;

`ifdef BIT_SERIAL_SUB_EN
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub | cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   serial_fa_cell u_cell (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (carry_q),
      .s  (cell_s),
      .co (cell_co)
   );

   assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) accept = 1'b1;
         end
         StRun: begin
            // Result bits enter at the MSB so bit 0 lands in sum[0] after WIDTH steps.
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {cell_s, sum_q[WIDTH-1:1]};
            carry_d = cell_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_step) begin
               state_d = StDone;
               cout_d  = cell_co;
            end
         end
         StDone: begin
            if (start) accept = 1'b1;
            else       state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (accept) begin
         state_d = StRun;
         a_d     = a;
         b_d     = b_load;
         carry_d = carry_load;
         cnt_d   = '0;
         sum_d   = '0;
         cout_d  = 1'b0;
      end

      busy_d = (state_d == StRun);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
